// File: rtl/sec_filter_out_stage.sv
// Output stage for the serial FIR filter: rounds and saturates each full-precision result,
// then buffers it in a first-word-fall-through FIFO read through a valid/ready handshake.
module sec_filter_out_stage #(
  parameter int unsigned Win   = 16,
  parameter int unsigned Wc    = 18,
  parameter int unsigned SHIFT = 17,
  parameter int unsigned Wout  = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [Win+Wc-1:0]      din,
  input  logic                   val_in,
  output logic [Wout-1:0]        dout,
  output logic                   val_out,
  input  logic                   rdy_in,
  output logic                   full,
  output logic                   sat_flag,
  output logic                   drop_flag,
  input  logic                   clr_flags
);

  localparam int unsigned Wfull = Win + Wc;
  localparam int unsigned Wext  = Wfull + 1;
  localparam int unsigned Aw    = $clog2(DEPTH);
  localparam int unsigned Cw    = $clog2(DEPTH + 1);

  localparam logic signed [Wext-1:0] RoundK = {{(Wext-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [Wext-1:0] SatMax = {{(Wext-Wout+1){1'b0}}, {(Wout-1){1'b1}}};
  localparam logic signed [Wext-1:0] SatMin = {{(Wext-Wout+1){1'b1}}, {(Wout-1){1'b0}}};

  logic signed [Wext-1:0] din_ext, rnd_sum, rnd_val;
  logic signed [Wext-1:0] r1_q, r1_d;
  logic                   v1_q;

  logic [Wout-1:0] sat_val;
  logic            sat_hit;

  logic [Wout-1:0] mem_q [DEPTH];
  logic [Aw-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Cw-1:0]   cnt_q, cnt_d;
  logic            sat_q, sat_d, drop_q, drop_d;
  logic            push, pop, wr_en, drop;

  // Round half up: bias by half an output LSB, then floor via arithmetic shift.
  assign din_ext = {din[Wfull-1], din};
  assign rnd_sum = din_ext + RoundK;
  assign rnd_val = rnd_sum >>> SHIFT;
  assign r1_d    = val_in ? rnd_val : r1_q;

  always_comb begin
    sat_hit = 1'b0;
    sat_val = r1_q[Wout-1:0];
    if (r1_q > SatMax) begin
      sat_hit = 1'b1;
      sat_val = SatMax[Wout-1:0];
    end else if (r1_q < SatMin) begin
      sat_hit = 1'b1;
      sat_val = SatMin[Wout-1:0];
    end
  end

  assign val_out = (cnt_q != '0);
  assign full    = (cnt_q == Cw'(DEPTH));
  assign dout    = val_out ? mem_q[rptr_q] : '0;

  // A write into a full FIFO only lands when the head is popped in the same cycle.
  assign push  = v1_q;
  assign pop   = val_out & rdy_in;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_en) wptr_d = wptr_q + Aw'(1);
    if (pop)   rptr_d = rptr_q + Aw'(1);
    unique case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + Cw'(1);
      2'b01:   cnt_d = cnt_q - Cw'(1);
      default: cnt_d = cnt_q;
    endcase
    sat_d  = (sat_q & ~clr_flags) | (v1_q & sat_hit);
    drop_d = (drop_q & ~clr_flags) | drop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_q   <= '0;
      v1_q   <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      r1_q   <= r1_d;
      v1_q   <= val_in;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
      drop_q <= drop_d;
    end
  end

  // Storage needs no reset: entries are only visible while the count says they are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= sat_val;
  end

  assign sat_flag  = sat_q;
  assign drop_flag = drop_q;

endmodule
